aidc_lite_ahb_sram_slv: RTL and testbench

- AHB2 responder (slave) placed in front of a single-port synchronous SRAM.
- It is the memory-side counterpart to the AIDC Lite bus masters. It serves their 4B x 16-beat INCR bursts, both read (source fetch) and write (compressed write-back).
- Zero-wait-state on reads and writes except when a write data phase collides with a read address phase on the single SRAM port.
- Illegal size/alignment produces a two-cycle ERROR response.

---
 rtl/aidc_lite_ahb_sram_slv_if.sv | 27 ++
 rtl/aidc_lite_ahb_sram_slv.sv | 178 +++++++++++++++++
 tb/tb_aidc_lite_ahb_sram_slv.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aidc_lite_ahb_sram_slv_if.sv
// AHB2 bus bundle between a bus master/decoder and the SRAM responder.
interface aidc_lite_ahb_sram_slv_if;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [2:0]  hburst_i;
  logic [3:0]  hprot_i;
  logic [31:0] hwdata_i;
  logic        hready_i;
  logic        hreadyout_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;

  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i,
           hwdata_i, hready_i,
    input  hreadyout_o, hresp_o, hrdata_o
  );

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i,
           hwdata_i, hready_i,
    output hreadyout_o, hresp_o, hrdata_o
  );
endinterface

// File: rtl/aidc_lite_ahb_sram_slv.sv
// AHB2 responder in front of a single-port synchronous SRAM.
// Zero-wait reads/writes; one wait when a write data phase meets a read
// address phase on the shared SRAM port; two-cycle ERROR on bad size/alignment.
// Optional macro AIDC_LITE_AHB_SLV_WAIT_INJECT_EN adds WAIT_CYCLES wait states
// to every NONSEQ beat.
module aidc_lite_ahb_sram_slv #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aidc_lite_ahb_sram_slv_if.slave bus,
  output logic                    sram_cs_o,
  output logic                    sram_we_o,
  output logic [ADDR_W-1:0]       sram_addr_o,
  output logic [3:0]              sram_be_o,
  output logic [31:0]             sram_wdata_o,
  input  logic [31:0]             sram_rdata_i
);

  // state names the data phase currently on the bus
  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_WAIT, S_WR, S_ERR1, S_ERR2
`ifdef AIDC_LITE_AHB_SLV_WAIT_INJECT_EN
    , S_WAIT
`endif
  } state_t;

  state_t              state;
  logic                ready_q, resp_q;
  logic                wr_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          be_q;

  logic                open_ap, accept, a_err, inject, wait_rd, rd_now, rd_reg;
  logic [3:0]          a_be;
  logic [ADDR_W-1:0]   a_addr;
  logic                unused_ok;

  // address phases are only sampled where the previous data phase can end
  assign open_ap = (state == S_IDLE) | (state == S_RD) | (state == S_WR) | (state == S_ERR2);
  assign accept  = open_ap & bus.hsel_i & bus.hready_i & bus.htrans_i[1];
  assign a_addr  = bus.haddr_i[ADDR_W+1:2];
  assign unused_ok = ^{bus.hburst_i, bus.hprot_i, bus.haddr_i[31:ADDR_W+2]};

  // byte lanes and legality of the transfer on the address bus
  always_comb begin
    a_be  = 4'b1111;
    a_err = 1'b0;
    case (bus.hsize_i)
      3'd0: a_be = 4'b0001 << bus.haddr_i[1:0];
      3'd1: begin
        a_be  = bus.haddr_i[1] ? 4'b1100 : 4'b0011;
        a_err = bus.haddr_i[0];
      end
      3'd2: a_err = |bus.haddr_i[1:0];
      default: a_err = 1'b1;
    endcase
  end

`ifdef AIDC_LITE_AHB_SLV_WAIT_INJECT_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;
  assign inject  = (WAIT_CYCLES > 0) && (bus.htrans_i == 2'b10);
  // a delayed read is launched in the last wait cycle so data lands in S_RD
  assign wait_rd = (state == S_WAIT) && (cnt == '0) && !wr_q;
`else
  logic unused_noinj;
  assign inject       = 1'b0;
  assign wait_rd      = 1'b0;
  assign unused_noinj = ^{wr_q, 32'(WAIT_CYCLES)};
`endif

  // a read goes straight to the SRAM unless the port is busy with a write
  assign rd_now = accept & ~bus.hwrite_i & ~a_err & ~inject & (state != S_WR);
  assign rd_reg = (state == S_RD_WAIT) | wait_rd;

  // SRAM port: data-phase write wins, then deferred read, then fresh read
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = 4'b0000;
    sram_wdata_o = '0;
    if (rst_n) begin
      if (state == S_WR && !err_q) begin
        sram_cs_o    = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_q;
        sram_be_o    = be_q;
        sram_wdata_o = bus.hwdata_i;
      end else if (rd_reg) begin
        sram_cs_o   = 1'b1;
        sram_addr_o = addr_q;
        sram_be_o   = 4'b1111;
      end else if (rd_now) begin
        sram_cs_o   = 1'b1;
        sram_addr_o = a_addr;
        sram_be_o   = 4'b1111;
      end
    end
  end

  assign bus.hreadyout_o = ready_q;
  assign bus.hresp_o     = resp_q;
  assign bus.hrdata_o    = (state == S_RD) ? sram_rdata_i : '0;

  // data-phase FSM with registered HREADYOUT/HRESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
`ifdef AIDC_LITE_AHB_SLV_WAIT_INJECT_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        S_RD_WAIT: begin
          state   <= S_RD;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
`ifdef AIDC_LITE_AHB_SLV_WAIT_INJECT_EN
        S_WAIT: begin
          if (cnt == '0) begin
            state   <= wr_q ? S_WR : S_RD;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          if (accept) begin
            wr_q   <= bus.hwrite_i;
            addr_q <= a_addr;
            be_q   <= a_be;
            err_q  <= a_err;
            if (a_err) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end
`ifdef AIDC_LITE_AHB_SLV_WAIT_INJECT_EN
            else if (inject) begin
              state   <= S_WAIT;
              ready_q <= 1'b0;
              cnt     <= CNT_W'(WAIT_CYCLES - 1);
            end
`endif
            else if (bus.hwrite_i) begin
              state <= S_WR;
            end else if (state == S_WR) begin
              state   <= S_RD_WAIT;
              ready_q <= 1'b0;
            end else begin
              state <= S_RD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_lite_ahb_sram_slv.sv
// Randomized AHB master + transaction-level reference model for the SRAM responder.
module tb_aidc_lite_ahb_sram_slv;
  localparam int AW = 12;
  localparam int WC = 3;
`ifdef AIDC_LITE_AHB_SLV_WAIT_INJECT_EN
  localparam int INJ_W = WC;
`else
  localparam int INJ_W = 0;
`endif
  localparam int COLL = (INJ_W == 0) ? 1 : 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aidc_lite_ahb_sram_slv_if bus();
  assign bus.hready_i = bus.hreadyout_o;

  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  bit   [31:0]   sram_rdata;

  aidc_lite_ahb_sram_slv #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_be_o(sram_be), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  // physical SRAM seen by the DUT
  bit [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
    if (sram_cs && sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  typedef struct {
    bit        idle;
    bit        wr;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [1:0]  trans;
    bit [31:0] data;
    int        tag;
  } tx_t;

  bit [31:0]   ref_mem [0:(1<<AW)-1];
  tx_t         txq[$];
  tx_t         ap, dp;
  bit          ap_v, dp_v;
  int          dp_cyc, dp_waits;
  int          checks, errors;
  int          nwait, nresp, ndp;
  logic [31:0] rd_log[$];
  logic [3:0]  be_log[$];
  int          rst_tag = -1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_err(tx_t t);
    return t.size > 3'd2 || (t.size == 3'd1 && t.addr[0]) || (t.size == 3'd2 && t.addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] lanes(tx_t t);
    logic [3:0] m = 4'b0000;
    int idx;
    for (int i = 0; i < (1 << t.size); i++) begin
      idx = int'(t.addr[1:0]) + i;
      m[idx[1:0]] = 1'b1;
    end
    return m;
  endfunction

  // wait states a beat must see, from the bus-level rules only
  function automatic int waits_for(tx_t t, bit prev_v, tx_t prev);
    if (is_err(t)) return 1;
    if (INJ_W > 0 && t.trans == 2'b10) return INJ_W;
    if (!t.wr && prev_v && prev.wr && !is_err(prev)) return 1;
    return 0;
  endfunction

  task automatic q_tx(bit wr, bit [31:0] a, bit [2:0] sz, bit [1:0] tr, bit [31:0] d, int tag);
    tx_t t;
    t.idle = 1'b0; t.wr = wr; t.addr = a; t.size = sz; t.trans = tr; t.data = d; t.tag = tag;
    txq.push_back(t);
  endtask

  task automatic q_idle(int n);
    tx_t t;
    t.idle = 1'b1; t.wr = 1'b0; t.addr = '0; t.size = '0; t.trans = '0; t.data = '0; t.tag = -1;
    repeat (n) txq.push_back(t);
  endtask

  task automatic q_burst(bit wr, bit [31:0] base, int n, bit [2:0] sz, bit [31:0] dbase, bit rnd, int tagb);
    for (int i = 0; i < n; i++)
      q_tx(wr, base + 32'(i << sz), sz, (i == 0) ? 2'b10 : 2'b11,
           rnd ? 32'($urandom) : dbase + 32'(i), (tagb < 0) ? -1 : tagb + i);
  endtask

  task automatic clr();
    nwait = 0; nresp = 0; ndp = 0;
    rd_log.delete(); be_log.delete();
  endtask

  task automatic drive();
    if (ap_v) begin
      bus.hsel_i = 1'b1; bus.htrans_i = ap.trans; bus.haddr_i = ap.addr;
      bus.hwrite_i = ap.wr; bus.hsize_i = ap.size;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin bus.hsel_i = 1'b0; bus.htrans_i = 2'($urandom); end
        1:       begin bus.hsel_i = 1'b1; bus.htrans_i = 2'b00; end
        default: begin bus.hsel_i = 1'b1; bus.htrans_i = 2'b01; end
      endcase
      bus.haddr_i = $urandom; bus.hwrite_i = 1'($urandom); bus.hsize_i = 3'($urandom);
    end
    bus.hburst_i = 3'($urandom);
    bus.hprot_i  = 4'($urandom);
    bus.hwdata_i = (dp_v && dp.wr) ? dp.data : $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.hsel_i = 1'b0; bus.htrans_i = 2'b00;
    @(negedge clk);
    chk("rst_first_we", 32'(sram_we), 0);
    chk("rst_first_cs", 32'(sram_cs), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_hreadyout", 32'(bus.hreadyout_o), 1);
    chk("rst_hresp", 32'(bus.hresp_o), 0);
    chk("rst_hrdata", bus.hrdata_o, 0);
    chk("rst_cs", 32'(sram_cs), 0);
    chk("rst_we", 32'(sram_we), 0);
    rst_n = 1'b1;
    txq.delete(); ap_v = 1'b0; dp_v = 1'b0; rst_tag = -1;
  endtask

  // one bus cycle: drive, compare DUT against the model, advance the pipeline
  task automatic step();
    bit          last;
    logic [31:0] exp_rd;
    int          w;
    tx_t         t;
    @(posedge clk); #1;
    if (dp_v && dp.tag >= 0 && dp.tag == rst_tag && dp_cyc == 0) begin
      do_reset();
      return;
    end
    drive();
    @(negedge clk);
    last = dp_v && (dp_cyc == dp_waits);
    if (dp_v) ndp++;
    if (!bus.hreadyout_o) nwait++;
    if (bus.hresp_o) nresp++;
    w = int'(dp.addr[AW+1:2]);
    exp_rd = (last && !dp.wr && !is_err(dp)) ? ref_mem[w] : 32'h0;
    chk("hreadyout", 32'(bus.hreadyout_o), dp_v ? 32'(last) : 32'd1);
    chk("hresp", 32'(bus.hresp_o), 32'(dp_v && is_err(dp)));
    chk("hrdata", bus.hrdata_o, exp_rd);
    if (dp_v && is_err(dp) && dp_cyc == 0) chk("err_no_sram", 32'(sram_cs), 0);
    if (last && dp.wr && !is_err(dp)) begin
      chk("wr_strobe", 32'({sram_cs, sram_we}), 3);
      chk("wr_addr", 32'(sram_addr), 32'(w));
      chk("wr_be", 32'(sram_be), 32'(lanes(dp)));
      chk("wr_data", sram_wdata, dp.data);
      be_log.push_back(sram_be);
      for (int b = 0; b < 4; b++)
        if (lanes(dp)[b]) ref_mem[w][8*b +: 8] = dp.data[8*b +: 8];
    end
    if (last && !dp.wr && !is_err(dp)) rd_log.push_back(bus.hrdata_o);
    if (bus.hreadyout_o) begin
      if (ap_v) begin
        dp_waits = waits_for(ap, dp_v, dp);
        dp = ap; dp_v = 1'b1; dp_cyc = 0;
      end else begin
        dp_v = 1'b0;
      end
      if (txq.size() > 0) begin
        t = txq.pop_front();
        ap = t; ap_v = !t.idle;
      end else begin
        ap_v = 1'b0;
      end
    end else begin
      dp_cyc++;
    end
  endtask

  task automatic run_queue(int budget, string nm);
    int n = 0;
    while ((txq.size() > 0 || ap_v || dp_v) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required<%0d", nm, n, budget);
      txq.delete(); ap_v = 1'b0; dp_v = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n;
    bit [2:0] sz;
    checks = 0; errors = 0; ap_v = 0; dp_v = 0;
    bus.hsel_i = 0; bus.htrans_i = 0; bus.haddr_i = 0; bus.hwrite_i = 0;
    bus.hsize_i = 0; bus.hburst_i = 0; bus.hprot_i = 0; bus.hwdata_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hreadyout", 32'(bus.hreadyout_o), 1);
    chk("reset_hresp", 32'(bus.hresp_o), 0);
    chk("reset_hrdata", bus.hrdata_o, 0);
    chk("reset_cs_we", 32'({sram_cs, sram_we}), 0);
    rst_n = 1'b1;

    // 16-beat write burst then an immediate 16-beat read burst
    clr();
    q_burst(1, 32'h100, 16, 3'd2, 32'hA000_0000, 0, -1);
    q_burst(0, 32'h100, 16, 3'd2, 0, 0, -1);
    run_queue(500, "burst_wr_rd");
    chk("burst_waits", nwait, 2 * INJ_W + COLL);
    chk("burst_data_cycles", ndp, 32 + 2 * INJ_W + COLL);
    chk("burst_rd_count", rd_log.size(), 16);
    for (int i = 0; i < 16 && i < rd_log.size(); i++)
      chk("burst_rd_lit", rd_log[i], 32'hA000_0000 + 32'(i));

    // single write then read of the same word in the next address phase
    clr();
    q_tx(1, 32'h40, 3'd2, 2'b10, 32'h1234_5678, -1);
    q_tx(0, 32'h40, 3'd2, 2'b10, 0, -1);
    run_queue(100, "collision");
    chk("coll_waits", nwait, 2 * INJ_W + COLL);
    chk("coll_rd", (rd_log.size() > 0) ? rd_log[0] : 32'hx, 32'h1234_5678);

    // byte and halfword merges into a full word
    clr();
    q_tx(1, 32'h0, 3'd2, 2'b10, 32'hFFFF_FFFF, -1); q_idle(1);
    q_tx(1, 32'h2, 3'd0, 2'b10, 32'h0011_0000, -1); q_idle(1);
    q_tx(1, 32'h0, 3'd1, 2'b10, 32'h0000_2233, -1); q_idle(1);
    q_tx(0, 32'h0, 3'd2, 2'b10, 0, -1);
    run_queue(100, "subword");
    chk("be_byte", (be_log.size() > 2) ? 32'(be_log[1]) : 32'hx, 32'h4);
    chk("be_half", (be_log.size() > 2) ? 32'(be_log[2]) : 32'hx, 32'h3);
    chk("subword_rd", (rd_log.size() > 0) ? rd_log[0] : 32'hx, 32'hFF11_2233);

    // misaligned word and oversize transfers, each followed by a good read
    clr();
    q_tx(1, 32'h80, 3'd2, 2'b10, 32'hCAFE_F00D, -1); q_idle(1);
    q_tx(1, 32'h6, 3'd2, 2'b10, 32'h5555_5555, -1);
    q_tx(0, 32'h80, 3'd2, 2'b10, 0, -1); q_idle(1);
    q_tx(0, 32'h0, 3'd3, 2'b10, 0, -1);
    q_tx(0, 32'h80, 3'd2, 2'b10, 0, -1);
    run_queue(100, "errors");
    chk("err_resp_cycles", nresp, 4);
    chk("err_waits", nwait, 2 + 3 * INJ_W);
    chk("err_rd0", (rd_log.size() > 1) ? rd_log[0] : 32'hx, 32'hCAFE_F00D);
    chk("err_rd1", (rd_log.size() > 1) ? rd_log[1] : 32'hx, 32'hCAFE_F00D);
    chk("err_mem_untouched", mem[1], 32'h0);

    // read-only burst: only the NONSEQ beat may stall
    clr();
    q_burst(0, 32'h100, 16, 3'd2, 0, 0, -1);
    run_queue(200, "rd_burst");
    chk("rd_burst_waits", nwait, INJ_W);
    chk("rd_burst_first", (rd_log.size() > 0) ? rd_log[0] : 32'hx, 32'hA000_0000);

    // reset during the data phase of beat 5 of a write burst
    clr();
    q_burst(1, 32'h200, 8, 3'd2, 32'hC000_0000, 0, -1);
    run_queue(100, "prefill");
    rst_tag = 5;
    q_burst(1, 32'h200, 8, 3'd2, 32'hB000_0000, 0, 0);
    run_queue(100, "reset_burst");
    clr();
    q_burst(0, 32'h200, 8, 3'd2, 0, 0, -1);
    run_queue(100, "reset_readback");
    chk("rst_beat4_written", (rd_log.size() > 7) ? rd_log[4] : 32'hx, 32'hB000_0004);
    chk("rst_beat5_kept", (rd_log.size() > 7) ? rd_log[5] : 32'hx, 32'hC000_0005);
    chk("rst_beat7_kept", (rd_log.size() > 7) ? rd_log[7] : 32'hx, 32'hC000_0007);

    // randomized bursts, singles, errors and idle gaps
    clr();
    repeat (80) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        sz = 3'($urandom_range(1, 7));
        q_tx(1'($urandom), 32'($urandom_range(0, 1023)) | 32'h1, sz, 2'b10, $urandom, -1);
      end else begin
        sz = 3'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
          0: n = 1; 1: n = 4; 2: n = 8; default: n = 16;
        endcase
        q_burst(1'($urandom), 32'($urandom_range(0, 255)) << 2, n, sz, 0, 1, -1);
      end
      q_idle($urandom_range(0, 2));
    end
    run_queue(20000, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
